// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared opcodes, FSM state encoding and flag bit positions
//                for the multicycle ALU.
//  Revision    : 1.0  initial release
// ============================================================================
package alu_pkg;

  localparam int OPW = 4;

  localparam logic [OPW-1:0] OP_AND  = 4'b0000;
  localparam logic [OPW-1:0] OP_OR   = 4'b0001;
  localparam logic [OPW-1:0] OP_ADD  = 4'b0010;
  localparam logic [OPW-1:0] OP_SUB  = 4'b0110;
  localparam logic [OPW-1:0] OP_PASSB = 4'b0111;
  localparam logic [OPW-1:0] OP_NOR  = 4'b1100;
  localparam logic [OPW-1:0] OP_MUL  = 4'b1000;
  localparam logic [OPW-1:0] OP_UDIV = 4'b1001;
  localparam logic [OPW-1:0] OP_UREM = 4'b1010;

  // Flag vector is {N,Z,C,V}
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } alu_state_e;

endpackage
`default_nettype wire

// File: rtl/muldiv_iter.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_iter
//  Description : One-bit-per-cycle iterative unsigned multiplier (shift-add)
//                and restoring divider. Runs exactly N steps after start;
//                done is raised during the last step with the final value
//                already presented on result.
//  Revision    : 1.0  initial release
// ============================================================================
module muldiv_iter #(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         is_div,
  input  logic         want_rem,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         done,
  output logic [N-1:0] result
);

  localparam int CW = $clog2(N);

  // acc : product accumulator (mul) or partial remainder (div)
  // sreg: multiplier shifting right (mul) or dividend->quotient shifting left (div)
  // opb : multiplicand shifting left (mul) or fixed divisor (div)
  logic          busy;
  logic          div_mode;
  logic          rem_mode;
  logic [CW-1:0] cnt;
  logic [N-1:0]  acc, sreg, opb;
  logic [N-1:0]  acc_nx, sreg_nx, opb_nx;
  logic [N:0]    shifted, trial;

  // One iteration step of whichever operation is running
  always_comb begin
    shifted = {acc, sreg[N-1]};
    trial   = shifted - {1'b0, opb};
    if (div_mode) begin
      // A non-negative trial means the divisor fits: keep it, quotient bit 1
      if (!trial[N]) begin
        acc_nx  = trial[N-1:0];
        sreg_nx = {sreg[N-2:0], 1'b1};
      end else begin
        acc_nx  = shifted[N-1:0];
        sreg_nx = {sreg[N-2:0], 1'b0};
      end
      opb_nx = opb;
    end else begin
      acc_nx  = acc + (sreg[0] ? opb : '0);
      sreg_nx = sreg >> 1;
      opb_nx  = opb << 1;
    end
  end

  assign done   = busy && (cnt == CW'(N - 1));
  assign result = (div_mode && !rem_mode) ? sreg_nx : acc_nx;

  // Operand load on start, then N iteration steps; reset aborts silently
  always_ff @(posedge clk) begin
    if (rst) begin
      busy     <= 1'b0;
      cnt      <= '0;
      div_mode <= 1'b0;
      rem_mode <= 1'b0;
      acc      <= '0;
      sreg     <= '0;
      opb      <= '0;
    end else if (start) begin
      busy     <= 1'b1;
      cnt      <= '0;
      div_mode <= is_div;
      rem_mode <= want_rem;
      acc      <= '0;
      sreg     <= is_div ? a : b;
      opb      <= is_div ? b : a;
    end else if (busy) begin
      acc  <= acc_nx;
      sreg <= sreg_nx;
      opb  <= opb_nx;
      cnt  <= cnt + CW'(1);
      if (done) busy <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_alu.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_alu
//  Description : Valid/ready ALU. Logic ops, add and sub finish in one cycle;
//                multiply and divide iterate one bit per cycle in
//                muldiv_iter. The result is held in DONE until taken.
//  Revision    : 1.0  initial release
// ============================================================================
module multicycle_alu
  import alu_pkg::*;
#(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] input_data_1,
  input  logic [N-1:0] input_data_2,
  input  logic [3:0]   input_opcode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] output_data,
  output logic [3:0]   output_flags,
  output logic         output_illegal
);

  alu_state_e   state, state_nx;
  logic         accept, b_zero, is_iter;
  logic         mdu_done;
  logic [N-1:0] mdu_result;
  logic [N-1:0] alu_res;
  logic [3:0]   alu_flags;
  logic         alu_illegal;
  logic [N:0]   sum;

  assign accept  = in_valid && in_ready;
  assign b_zero  = (input_data_2 == '0);
  // Divide by zero bypasses the iterator and completes in one cycle
  assign is_iter = (input_opcode == OP_MUL) ||
                   (((input_opcode == OP_UDIV) || (input_opcode == OP_UREM)) && !b_zero);

  // Single-cycle result, flags and illegal decode from the live request
  always_comb begin
    alu_res     = '0;
    alu_flags   = '0;
    alu_illegal = 1'b0;
    sum         = {1'b0, input_data_1} + {1'b0, input_data_2};
    case (input_opcode)
      OP_ADD: begin
        alu_res           = sum[N-1:0];
        alu_flags[FLAG_C] = sum[N];
        alu_flags[FLAG_V] = (input_data_1[N-1] == input_data_2[N-1]) &&
                            (sum[N-1] != input_data_1[N-1]);
      end
      OP_SUB: begin
        alu_res           = input_data_1 - input_data_2;
        alu_flags[FLAG_C] = (input_data_1 >= input_data_2);
        alu_flags[FLAG_V] = (input_data_1[N-1] != input_data_2[N-1]) &&
                            (alu_res[N-1] != input_data_1[N-1]);
      end
      OP_AND:   alu_res = input_data_1 & input_data_2;
      OP_OR:    alu_res = input_data_1 | input_data_2;
      OP_PASSB: alu_res = input_data_2;
      OP_NOR:   alu_res = ~(input_data_1 | input_data_2);
      OP_MUL:   alu_res = '0;
      OP_UDIV:  alu_res = '1;            // only used when B == 0
      OP_UREM:  alu_res = input_data_1;  // only used when B == 0
      default:  alu_illegal = 1'b1;
    endcase
    if (!alu_illegal) begin
      alu_flags[FLAG_N] = alu_res[N-1];
      alu_flags[FLAG_Z] = (alu_res == '0);
    end
  end

  muldiv_iter #(.N(N)) u_muldiv (
    .clk      (clk),
    .rst      (rst),
    .start    (accept && is_iter),
    .is_div   (input_opcode != OP_MUL),
    .want_rem (input_opcode == OP_UREM),
    .a        (input_data_1),
    .b        (input_data_2),
    .done     (mdu_done),
    .result   (mdu_result)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state decode
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (in_valid) begin
          if (input_opcode == OP_MUL) state_nx = MUL;
          else if (is_iter)           state_nx = DIV;
          else                        state_nx = DONE;
        end
      end
      MUL, DIV: if (mdu_done)  state_nx = DONE;
      DONE:     if (out_ready) state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  // Handshake outputs from state
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Result registers: loaded on completion and held until the next one
  always_ff @(posedge clk) begin
    if (rst) begin
      output_data    <= '0;
      output_flags   <= '0;
      output_illegal <= 1'b0;
    end else if (accept && !is_iter) begin
      output_data    <= alu_res;
      output_flags   <= alu_flags;
      output_illegal <= alu_illegal;
    end else if (mdu_done && (state != IDLE)) begin
      output_data    <= mdu_result;
      output_flags   <= {mdu_result[N-1], (mdu_result == '0), 2'b00};
      output_illegal <= 1'b0;
    end
  end

endmodule
`default_nettype wire
